// File: rtl/ifetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> HOLD loop with branch/jump next-PC selection.
// Optional IFETCH_PERF_COUNT_EN macro enables the accepted-instruction counter on fetch_count.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ext_imm,
  input  logic [25:0] target26,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        accept;

  // Handshakes: memory side completes when imem_req && imem_ready; decode side
  // takes the instruction when instr_valid && instr_ack. Both strobes are ignored
  // whenever their own request/valid is low.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;
  assign state_dbg   = state;
  assign accept      = (state == HOLD) && instr_ack;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], target26, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + (ext_imm << 2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_PERF_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign fetch_count   = '0;
`endif

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, address of first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ext_imm  input  32  extended immediate from the Signextend stage (Dout), branch offset in words.
REQ-005 SHALL have port target26  input  26  jump target field of current instruction.
REQ-006 SHALL have ports branch, zero, jump  input  1 each  decoder branch flag, ALU zero flag, decoder jump flag.
REQ-007 SHALL have ports imem_req  output  1  and imem_addr  output  32  instruction memory request and word address.
REQ-008 SHALL have ports imem_ready  input  1  and imem_rdata  input  32  memory completion strobe and data.
REQ-009 SHALL have ports instr  output  32, instr_valid  output  1, instr_ack  input  1  instruction handoff to decode.
REQ-010 SHALL have port pc  output  32  address of instruction currently held or being fetched.
REQ-011 SHALL have port fetch_count  output  32  count of accepted instructions (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-013 IDLE: one cycle after reset release; unconditional transition to FETCH.
REQ-014 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1 capture imem_rdata into instr, go HOLD; otherwise stay FETCH with stable address.
REQ-015 HOLD: instr_valid=1, instr stable; on instr_ack=1 update pc to next PC, go FETCH; otherwise stay HOLD.
REQ-016 Minimum latency: imem_ready in the first FETCH cycle -> instr_valid the next cycle.
REQ-017 Next PC priority: jump=1 -> {pc_plus4[31:28], target26, 2'b00}; else branch=1 and zero=1 -> pc_plus4 + (ext_imm << 2); else pc_plus4.
REQ-018 pc_plus4 = pc + 4; all PC arithmetic modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000); negative ext_imm yields backward target.
REQ-019 branch, zero, jump, ext_imm, target26 SHALL be sampled only in the HOLD cycle where instr_ack=1; ignored otherwise.
REQ-020 instr_ack outside HOLD, and imem_ready outside FETCH, SHALL be ignored with no state change.
REQ-021 imem_req and instr_valid SHALL never be 1 in the same cycle.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_count=0.
REQ-023 rst during FETCH SHALL abandon the request; imem_req=0 from the following cycle; a late imem_ready is ignored.
REQ-024 rst during HOLD SHALL discard the held instruction; no pc update occurs even if instr_ack=1 in that cycle.

Configuration
REQ-025 Macro IFETCH_PERF_COUNT_EN: when defined, fetch_count increments by 1 (wrapping at 2^32) on each HOLD cycle with instr_ack=1.
REQ-026 Without IFETCH_PERF_COUNT_EN, the fetch_count port SHALL exist and be constant 0; no counter register is synthesized.

Verification
REQ-027 Reset, then imem_ready=1 always, instr_ack=1 always -> imem_addr sequence 0x3000, 0x3004, 0x3008; instr_valid every second cycle.
REQ-028 At pc=0x3010: ack with branch=1, zero=1, ext_imm=0xFFFF_FFFC -> next imem_addr 0x3004; with zero=0 -> 0x3014.
REQ-029 At pc=0x3000: ack with jump=1, branch=1, zero=1, target26=0x000_0C10 -> next imem_addr 0x0000_3040 (jump wins).
REQ-030 imem_ready held low 5 cycles in FETCH -> imem_req=1, address stable, instr_valid=0 throughout; instr equals imem_rdata sampled on ready.
REQ-031 rst asserted in HOLD with instr_ack=1 -> next cycle pc=RESET_PC, instr_valid=0, fetch_count=0.
REQ-032 With IFETCH_PERF_COUNT_EN defined, 3 accepted instructions -> fetch_count=3; undefined -> fetch_count=0.
